// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    // Payload is zero-extended to MAX_DATA_BITS, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input parity_e mode);
        logic p;
        p = ^data;
        if (mode == PAR_ODD) begin
            p = ~p;
        end else if (mode != PAR_EVEN) begin
            p = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// Receive path: 2-flop synchroniser, bit-centre sampling FSM, parity/framing checks.
// Latency: frame_vld pulses in the cycle the first stop bit is sampled (2 cycles sync delay).
// Backpressure: none; frames are offered for one cycle and the consumer must take or drop them.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 16,
    parameter int      DATA_BITS    = 8,
    parameter parity_e PMODE        = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_t,
    output logic                 frame_vld,
    output logic [DATA_BITS-1:0] frame_dat,
    output logic                 frame_par_err,
    output logic                 frame_frm_err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);

    logic [1:0]           sync;
    logic                 rx_s;
    logic                 rx_prev;
    rx_state_e            state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [3:0]           bidx, bidx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par_bit, par_bit_d;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bidx    <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            sync    <= {sync[0], rx_t};
            rx_prev <= rx_s;
            state   <= state_d;
            cnt     <= cnt_d;
            bidx    <= bidx_d;
            shreg   <= shreg_d;
            par_bit <= par_bit_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bidx_d    = bidx;
        shreg_d   = shreg;
        par_bit_d = par_bit;
        frame_vld = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at its centre was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    bidx_d  = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bidx == DATA_LAST) begin
                        state_d = (PMODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bidx_d = bidx + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d     = '0;
                    frame_vld = 1'b1;
                    state_d   = rx_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    assign frame_dat     = shreg;
    assign frame_par_err = (PMODE != PAR_NONE) && (par_bit != calc_parity(9'(shreg), PMODE));
    assign frame_frm_err = ~rx_s;

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART with configurable frame format; TX FSM plus RX output holding register.
// Latency: tx_t starts 1 cycle after handshake; rx_valid 1 cycle after the stop-bit sample.
// Backpressure: tx_ready only in TX idle; an unaccepted RX frame drops newer ones (rx_overrun).
module uart_param_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_t,
    input  logic                 rx_t,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    if (CLKS_PER_BIT < 4) begin : g_err_cpb
        $error("CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_err_db
        $error("DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $error("STOP_BITS must be 1 or 2");
    end

    localparam parity_e        PMODE     = (PARITY == 1) ? PAR_ODD :
                                           (PARITY == 2) ? PAR_EVEN : PAR_NONE;
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e            tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d;
    logic [3:0]           tx_idx, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_bit_d;

    assign tx_ready = (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            tx_t     <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_shreg <= tx_shreg_d;
            tx_par   <= tx_par_d;
            tx_t     <= tx_bit_d;
        end
    end

    // tx_t is registered from the next-state view so the line follows the state with no skew.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 1'b1;
        tx_idx_d   = tx_idx;
        tx_shreg_d = tx_shreg;
        tx_par_d   = tx_par;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_shreg_d = tx_data;
                    tx_par_d   = calc_parity(9'(tx_data), PMODE);
                    tx_idx_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shreg_d = tx_shreg >> 1;
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = (PMODE == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_idx_d = tx_idx + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_idx_d = tx_idx + 4'd1;
                    end
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase

        case (tx_state_d)
            TX_START:  tx_bit_d = 1'b0;
            TX_DATA:   tx_bit_d = tx_shreg_d[0];
            TX_PARITY: tx_bit_d = tx_par_d;
            default:   tx_bit_d = 1'b1;
        endcase
    end

    logic                 frame_vld;
    logic [DATA_BITS-1:0] frame_dat;
    logic                 frame_par_err;
    logic                 frame_frm_err;
    logic                 rx_load;

    uart_rx_engine #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PMODE        (PMODE)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx_t          (rx_t),
        .frame_vld     (frame_vld),
        .frame_dat     (frame_dat),
        .frame_par_err (frame_par_err),
        .frame_frm_err (frame_frm_err)
    );

    // A frame arriving on the accepting cycle replaces the held one without loss.
    assign rx_load = frame_vld && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= frame_vld && rx_valid && !rx_ready;
            if (rx_load) begin
                rx_valid      <= 1'b1;
                rx_data       <= frame_dat;
                rx_parity_err <= frame_par_err;
                rx_frame_err  <= frame_frm_err;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench: TX waveform, loopback in two frame formats, RX error injection, glitch, overrun, reset.
module tb_uart_param_core;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_t;
    logic       rx_t;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       lb;
    logic       rx_drv;

    logic [7:0] tx2_data;
    logic       tx2_valid;
    logic       tx2_ready;
    logic       tx2_t;
    logic [7:0] rx2_data;
    logic       rx2_valid;
    logic       rx2_ready;
    logic       rx2_perr;
    logic       rx2_ferr;
    logic       rx2_ovr;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ovr2_cnt = 0;
    logic [9:0] q[$];
    logic [9:0] q2[$];

    assign rx_t = lb ? tx_t : rx_drv;

    uart_param_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_t(tx_t), .rx_t(rx_t), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    uart_param_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(tx2_ready),
        .tx_t(tx2_t), .rx_t(tx2_t), .rx_data(rx2_data), .rx_valid(rx2_valid), .rx_ready(rx2_ready),
        .rx_parity_err(rx2_perr), .rx_frame_err(rx2_ferr), .rx_overrun(rx2_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes are observed mid-low-phase, where inputs and outputs are both settled.
    always @(negedge clk) begin
        #2;
        if (rx_valid && rx_ready) q.push_back({rx_frame_err, rx_parity_err, rx_data});
        if (rx_overrun) ovr_cnt++;
        if (rx2_valid && rx2_ready) q2.push_back({rx2_ferr, rx2_perr, rx2_data});
        if (rx2_ovr) ovr2_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] got(input int idx);
        if (q.size() > idx) return q[idx];
        return 10'h3FF;
    endfunction

    function automatic logic [9:0] got2(input int idx);
        if (q2.size() > idx) return q2[idx];
        return 10'h3FF;
    endfunction

    task automatic wait_q(input int n);
        int t = 0;
        while (q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic tx_send(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_send_ready", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic tx2_send(input logic [7:0] d);
        int n = 0;
        while (!tx2_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx2_send_ready", tx2_ready, 1);
        tx2_data  = d;
        tx2_valid = 1'b1;
        @(negedge clk);
        tx2_valid = 1'b0;
    endtask

    // Drives one 16-clock-per-bit frame; optionally pulses rx_ready at cycle ack_at.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int ack_at);
        logic [10:0] fb;
        fb = {sbit, pbit, d, 1'b0};
        for (int k = 0; k < 176; k++) begin
            rx_drv = fb[k/16];
            if (k == ack_at) rx_ready = 1'b1;
            if (k == ack_at + 1) rx_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  d;
        logic [10:0] fb;
        int          good[11];
        int          rdy_low;
        int          o0;
        int          n;

        rst = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1; lb = 1'b1; rx_drv = 1'b1;
        tx2_data = '0; tx2_valid = 1'b0; rx2_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_t", tx_t, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_perr", rx_parity_err, 0);
        chk("rst_ferr", rx_frame_err, 0);
        chk("rst_ovr", rx_overrun, 0);
        rst = 1'b1;
        @(negedge clk);

        // TX 0xA5 waveform; a pending 0x3C is raised mid-frame and must wait for idle.
        d = 8'hA5;
        fb = {1'b1, ^d, d, 1'b0};
        foreach (good[i]) good[i] = 0;
        rdy_low = 0;
        tx_data = d; tx_valid = 1'b1;
        chk("tx_ready_idle", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 176; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_t === fb[k/16]) good[k/16]++;
            if (tx_ready === 1'b0) rdy_low++;
            if (k == 100) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
        end
        for (int b = 0; b < 11; b++) chk($sformatf("tx_bit%0d_cycles", b), good[b], 16);
        chk("tx_ready_low_cycles", rdy_low, 176);
        @(negedge clk);
        chk("tx_gap_line", tx_t, 1);
        chk("tx_gap_ready", tx_ready, 1);
        @(negedge clk);
        chk("tx_b2b_start", tx_t, 0);
        chk("tx_b2b_busy", tx_ready, 0);
        tx_valid = 1'b0;
        tx_send(8'hFF);
        wait_q(3);
        chk("lb_frame0", got(0), {2'b00, 8'hA5});
        chk("lb_frame1", got(1), {2'b00, 8'h3C});
        chk("lb_frame2", got(2), {2'b00, 8'hFF});

        // Odd parity, two stop bits.
        tx2_send(8'h3C);
        n = 0;
        while (tx2_ready === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("tx2_ready_low_cycles", n, 192);
        tx2_send(8'hFF);
        n = 0;
        while (q2.size() < 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("lb2_frame0", got2(0), {2'b00, 8'h3C});
        chk("lb2_frame1", got2(1), {2'b00, 8'hFF});

        // Bench-driven RX line.
        lb = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h01, 1'b0, 1'b1, 999);
        wait_q(4);
        chk("parity_err_frame", got(3), {2'b01, 8'h01});

        send_frame(8'h55, 1'b0, 1'b0, 999);
        repeat (24) @(negedge clk);
        chk("frame_err_frame", got(4), {2'b10, 8'h55});
        chk("break_no_extra", q.size(), 5);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        chk("break_release_no_frame", q.size(), 5);

        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_frame", q.size(), 5);
        send_frame(8'h7E, 1'b0, 1'b1, 999);
        wait_q(6);
        chk("after_glitch_frame", got(5), {2'b00, 8'h7E});

        // Overrun: second frame dropped while the first is held.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 999);
        send_frame(8'h22, 1'b0, 1'b1, 999);
        repeat (20) @(negedge clk);
        chk("ovr_held_valid", rx_valid, 1);
        chk("ovr_held_data", rx_data, 8'h11);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("ovr_cleared_valid", rx_valid, 0);
        chk("ovr_accepted", got(6), {2'b00, 8'h11});

        // 0x33 completes exactly on the cycle the held 0x44 is accepted.
        send_frame(8'h44, 1'b0, 1'b1, 999);
        send_frame(8'h33, 1'b0, 1'b1, 170);
        chk("sim_load_valid", rx_valid, 1);
        chk("sim_load_data", rx_data, 8'h33);
        chk("sim_load_no_ovr", ovr_cnt - o0, 1);
        chk("sim_load_prev", got(7), {2'b00, 8'h44});
        rx_ready = 1'b1;
        @(negedge clk);
        chk("sim_load_accepted", got(8), {2'b00, 8'h33});

        // Reset in the middle of a looped-back frame.
        lb = 1'b1;
        tx_send(8'h96);
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tx_t", tx_t, 1);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = q.size();
        repeat (300) @(negedge clk);
        chk("postrst_no_frame", q.size(), n);
        chk("postrst_tx_t", tx_t, 1);
        chk("postrst_tx_ready", tx_ready, 1);
        chk("dut2_no_overrun", ovr2_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised full-duplex UART core: the next generation of the fixed-format UART top. It has a configurable frame format (data bits, parity, stop bits) and a configurable bit period. It uses valid/ready handshakes on both the TX and RX byte interfaces, and adds RX error detection (parity, framing, overrun). It sits between the serial pins (tx_t/rx_t) and on-chip logic, replacing the fixed-format UART top.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 4 (elaboration error otherwise)
DATA_BITS, 8, payload bits per frame; legal range 5..9 (elaboration error otherwise)
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, TX stop bits: 1 or 2; RX always checks only the first stop bit

Ports:
clk  in  1  single clock; all logic is rising-edge
rst  in  1  reset, asynchronous assert, active-low
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  high only in TX IDLE; handshake = tx_valid & tx_ready
tx_t  out  1  serial output, idle high, registered
rx_t  in  1  serial input, asynchronous to clk
rx_data  out  DATA_BITS  received payload, held stable while rx_valid
rx_valid  out  1  received frame available
rx_ready  in  1  consumer accepts rx_data
rx_parity_err  out  1  parity mismatch on the held frame; qualified by rx_valid
rx_frame_err  out  1  first stop bit sampled low on the held frame; qualified by rx_valid
rx_overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (rst=0), taking effect immediately, including mid-frame:
  - tx_t=1, tx_ready=1, rx_valid=0, rx_data=0, all error outputs 0.
  - Both FSMs return to IDLE and all counters clear.
- Bit timer: counter of width $clog2(CLKS_PER_BIT), one per direction.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Handshake cycle: tx_data is latched.
  - From the next cycle: tx_t=0 for CLKS_PER_BIT cycles.
  - Then DATA_BITS data bits, LSB first.
  - Then the parity bit, if enabled: even mode = XOR of data; odd mode = its inverse.
  - Then STOP_BITS stop bits of 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx_ready is low from the cycle after the handshake until the last stop-bit cycle completes; it returns high in IDLE.
  - Back-to-back transmission: a new handshake in the first IDLE cycle starts the next start bit one cycle later, giving a 1-cycle idle gap.
  - tx_valid is ignored while tx_ready=0.
- RX synchroniser: rx_t passes through a 2-flop synchroniser. All RX decisions use the synchronised value (2-cycle latency).
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE, plus a BREAK state.
  - IDLE -> START on a synchronised high-to-low transition.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is high, treat as a glitch: return to IDLE, no output.
  - DATA/PARITY/STOP: sample every CLKS_PER_BIT cycles thereafter, at bit centres. Data is shifted LSB first.
  - After sampling the first stop bit, the FSM returns to IDLE immediately, so RX can catch a start bit during the TX-side second stop bit.
  - Stop bit sampled 0: frame_err is set, the frame is still delivered, and the FSM enters BREAK. It stays in BREAK until synchronised rx is high, then goes to IDLE.
- RX output handshake:
  - The frame is loaded into rx_data/flags, and rx_valid=1 in the cycle after the stop-bit sample.
  - rx_valid holds until rx_valid & rx_ready, then clears next cycle unless a new frame loads in that same cycle.
  - A frame completes while rx_valid=1 and rx_ready=0: the new frame is dropped, held data is unchanged, and rx_overrun pulses for 1 cycle.
  - A frame completes in the same cycle as an accepting handshake: the new frame loads, there is no overrun, and rx_valid stays high.
- With PARITY=0, rx_parity_err is constant 0.

Decomposition:
- Shared package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e and rx_state_e enums
  - a parity function(data, mode)
- One natural sub-module: uart_rx_engine. It contains the synchroniser, RX FSM, sampling and error generation.
- TX FSM and the output handshake register live in uart_param_core.

Test Plan:
Bench configuration for all scenarios: CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless stated.
- Reset: hold rst=0 during an active TX frame -> tx_t=1 and tx_ready=1 immediately; rx_valid=0; after rst=1, no residual frame.
- TX 0xA5 -> beginning the cycle after the handshake, tx_t = 0,1,0,1,0,0,1,0,1,0(parity),1, each 16 cycles; tx_ready low for 176 cycles; second 0x3C accepted in the first IDLE cycle.
- Loopback tx_t->rx_t, send 0x3C then 0xFF -> rx_valid with rx_data=0x3C, then 0xFF, parity_err=0, frame_err=0; repeat with PARITY=1 and STOP_BITS=2, same data.
- RX error injection:
  - 0x01 with parity bit 0 -> rx_parity_err=1, rx_data=0x01.
  - Valid frame 0x55 but stop bit 0, rx_t held low 40 cycles -> rx_frame_err=1; no new frame until rx_t high.
- Glitch: rx_t low for 4 cycles only -> no rx_valid, RX back in IDLE, and a following 0x7E frame is received correctly.
- Overrun: rx_ready=0, two frames 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses once. Then rx_ready=1 for 1 cycle -> rx_valid=0. Next frame 0x33 completing in the same cycle as a rx_ready handshake -> loaded, no overrun.
